// File: rtl/rr_otf_convert_pkg.sv
// rtl/rr_otf_convert_pkg.sv - shared widths, FSM state type for the on-the-fly converter
package rr_otf_convert_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  function automatic int digit_bits(input int radix);
    return $clog2(radix) + 1;
  endfunction

  function automatic int result_bits(input int radix, input int width);
    return width * $clog2(radix) + 1;
  endfunction

endpackage

// File: rtl/rr_otf_convert_if.sv
// rtl/rr_otf_convert_if.sv - digit-in / word-out handshake bundle (err only with RR_OTF_DIGIT_CHECK_EN)
interface rr_otf_convert_if #(
  parameter int RADIX = 4,
  parameter int WIDTH = 4
);
  localparam int D = rr_otf_convert_pkg::digit_bits(RADIX);
  localparam int B = rr_otf_convert_pkg::result_bits(RADIX, WIDTH);

  logic [D-1:0] d_in;
  logic         d_valid;
  logic         d_ready;
  logic [B-1:0] res;
  logic         res_valid;
  logic         res_ready;
`ifdef RR_OTF_DIGIT_CHECK_EN
  logic         err;

  modport master (output d_in, d_valid, res_ready, input d_ready, res, res_valid, err);
  modport slave  (input d_in, d_valid, res_ready, output d_ready, res, res_valid, err);
`else
  modport master (output d_in, d_valid, res_ready, input d_ready, res, res_valid);
  modport slave  (input d_in, d_valid, res_ready, output d_ready, res, res_valid);
`endif
endinterface

// File: rtl/rr_otf_convert_sd_digit_append.sv
// rtl/rr_otf_convert_sd_digit_append.sv - maps one signed digit to the Q/QM append values and source selects
module rr_otf_convert_sd_digit_append #(
  parameter int RADIX = 4
) (
  input  logic [$clog2(RADIX):0]   d,
  output logic [$clog2(RADIX)-1:0] q_app,
  output logic [$clog2(RADIX)-1:0] qm_app,
  output logic                     q_sel_qm,
  output logic                     qm_sel_q
);
  localparam int K = $clog2(RADIX);

  // RADIX+d and RADIX-1+d reduce mod RADIX to d and d-1, so only a K-bit decrement is needed.
  assign q_app    = d[K-1:0];
  assign qm_app   = d[K-1:0] - {{(K-1){1'b0}}, 1'b1};
  assign q_sel_qm = d[K];
  assign qm_sel_q = !d[K] && (|d);
endmodule

// File: rtl/rr_otf_convert.sv
// rtl/rr_otf_convert.sv - MSDF signed-digit to two's complement converter using the Q/QM pair
// Optional digit legality check under RR_OTF_DIGIT_CHECK_EN.
module rr_otf_convert
  import rr_otf_convert_pkg::*;
#(
  parameter int RADIX = 4,
  parameter int WIDTH = 4
) (
  input logic               clock,
  input logic               reset_n,
  rr_otf_convert_if.slave   io
);
  localparam int K  = $clog2(RADIX);
  localparam int D  = digit_bits(RADIX);
  localparam int B  = result_bits(RADIX, WIDTH);
  localparam int CW = $clog2(WIDTH);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [B-1:0]  q_q, q_d;
  logic [B-1:0]  qm_q, qm_d;
  logic [B-1:0]  res_q, res_d;
  logic          res_valid_q, res_valid_d;
  logic          d_ready;
  logic          accept;
  logic          last_digit;
  logic [K-1:0]  q_app, qm_app;
  logic          q_sel_qm, qm_sel_q;
  logic [B-1:0]  q_next, qm_next;

  rr_otf_convert_sd_digit_append #(.RADIX(RADIX)) u_append (
    .d        (io.d_in),
    .q_app    (q_app),
    .qm_app   (qm_app),
    .q_sel_qm (q_sel_qm),
    .qm_sel_q (qm_sel_q)
  );

  assign accept     = io.d_valid && d_ready;
  assign last_digit = (cnt_q == CW'(WIDTH - 1));
  assign q_next     = ((q_sel_qm ? qm_q : q_q) << K) | B'(q_app);
  assign qm_next    = ((qm_sel_q ? q_q : qm_q) << K) | B'(qm_app);

`ifdef RR_OTF_DIGIT_CHECK_EN
  logic err_q, err_d;
  logic illegal;

  assign illegal = accept && (io.d_in == {1'b1, {(D-1){1'b0}}});
  assign io.err  = err_q;

  // Sticky across the word; dropped once the consumer takes the result.
  always_comb begin
    err_d = err_q | illegal;
    if (state_q == DONE && io.res_ready) err_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      q_q         <= '0;
      qm_q        <= '1;
      res_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      q_q         <= q_d;
      qm_q        <= qm_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (accept && last_digit) state_d = DONE;
      DONE:    if (io.res_ready)         state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    q_d         = q_q;
    qm_d        = qm_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    if (accept) begin
      if (last_digit) begin
        res_d       = q_next;
        res_valid_d = 1'b1;
        cnt_d       = '0;
        q_d         = '0;
        qm_d        = '1;
      end else begin
        cnt_d = cnt_q + 1'b1;
        q_d   = q_next;
        qm_d  = qm_next;
      end
    end
    if (state_q == DONE && io.res_ready) res_valid_d = 1'b0;
  end

  // d_ready decodes the state flop only, so res_ready never reaches it combinationally.
  always_comb begin
    d_ready = (state_q == ACCUM);
  end

  assign io.d_ready   = d_ready;
  assign io.res       = res_q;
  assign io.res_valid = res_valid_q;
endmodule

// File: tb/tb_rr_otf_convert.sv
// tb/tb_rr_otf_convert.sv - directed checks of the radix-4, 4-digit converter
module tb_rr_otf_convert;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   fails = 0;

  rr_otf_convert_if #(.RADIX(4), .WIDTH(4)) bus ();

  rr_otf_convert #(.RADIX(4), .WIDTH(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .io      (bus)
  );

  always #5 clock = ~clock;

  task automatic send_word(input logic [11:0] w, input bit chk_inv);
    for (int i = 0; i < 4; i++) begin
      int n;
      n = 0;
      bus.d_in    = w[11-3*i -: 3];
      bus.d_valid = 1'b1;
      while (!bus.d_ready && n < 20) begin
        @(posedge clock); #1;
        n++;
      end
      checks++;
      if (bus.d_ready !== 1'b1) begin
        fails++;
        $display("FAIL d_ready_wait digit %0d: got %b want 1", i, bus.d_ready);
      end
      if (i == 3) begin
        checks++;
        if (bus.res_valid !== 1'b0) begin
          fails++;
          $display("FAIL res_valid_early: got %b want 0", bus.res_valid);
        end
      end
      @(posedge clock); #1;
      if (chk_inv) begin
        checks++;
        if (dut.qm_q !== 9'(dut.q_q - 9'd1)) begin
          fails++;
          $display("FAIL qm_invariant digit %0d: qm %h q %h", i, dut.qm_q, dut.q_q);
        end
      end
    end
    bus.d_valid = 1'b0;
    checks++;
    if (bus.res_valid !== 1'b1) begin
      fails++;
      $display("FAIL res_valid_latency: got %b want 1", bus.res_valid);
    end
  endtask

  task automatic check_res(input string name, input logic [8:0] exp);
    checks++;
    if (bus.res !== exp) begin
      fails++;
      $display("FAIL %s: res got %h want %h", name, bus.res, exp);
    end
  endtask

  task automatic consume(input logic [8:0] exp);
    bus.res_ready = 1'b1;
    @(posedge clock); #1;
    bus.res_ready = 1'b0;
    checks++;
    if (bus.res_valid !== 1'b0 || bus.d_ready !== 1'b1) begin
      fails++;
      $display("FAIL consume: res_valid %b d_ready %b want 0 1", bus.res_valid, bus.d_ready);
    end
    checks++;
    if (bus.res !== exp) begin
      fails++;
      $display("FAIL res_retained: got %h want %h", bus.res, exp);
    end
  endtask

  task automatic test_reset;
    checks++;
    if (bus.d_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.res !== 9'h000) begin
      fails++;
      $display("FAIL reset_state: d_ready %b res_valid %b res %h", bus.d_ready, bus.res_valid, bus.res);
    end
`ifdef RR_OTF_DIGIT_CHECK_EN
    checks++;
    if (bus.err !== 1'b0) begin
      fails++;
      $display("FAIL reset_err: got %b want 0", bus.err);
    end
`endif
  endtask

  task automatic test_basic_words;
    send_word({3'd3, 3'd0, 3'd0, 3'd0}, 1'b0);
    check_res("word_3000", 9'h0C0);
    consume(9'h0C0);
    send_word({3'b001, 3'b101, 3'b010, 3'b111}, 1'b1);
    check_res("word_1m32m1", 9'h017);
    consume(9'h017);
    send_word({3'b101, 3'b101, 3'b101, 3'b101}, 1'b1);
    check_res("word_m3x4", 9'h101);
    consume(9'h101);
    send_word(12'h000, 1'b0);
    check_res("word_zero", 9'h000);
    consume(9'h000);
  endtask

  task automatic test_back_to_back_stall;
    send_word({3'd1, 3'd1, 3'd1, 3'd1}, 1'b0);
    bus.d_in    = 3'd3;
    bus.d_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      checks++;
      if (bus.res !== 9'h055 || bus.res_valid !== 1'b1 || bus.d_ready !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold cycle %0d: res %h res_valid %b d_ready %b", c, bus.res, bus.res_valid, bus.d_ready);
      end
    end
    checks++;
    if (dut.cnt_q !== 2'd0) begin
      fails++;
      $display("FAIL stall_no_consume: cnt %0d want 0", dut.cnt_q);
    end
    bus.d_valid = 1'b0;
    consume(9'h055);
    send_word({3'd0, 3'd0, 3'd0, 3'd2}, 1'b0);
    check_res("word_after_stall", 9'h002);
    consume(9'h002);
  endtask

  task automatic test_reset_mid_word;
    bus.d_in    = 3'd1;
    bus.d_valid = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    bus.d_valid = 1'b0;
    reset_n = 1'b0;
    #2;
    checks++;
    if (bus.res_valid !== 1'b0 || bus.d_ready !== 1'b1 || dut.cnt_q !== 2'd0) begin
      fails++;
      $display("FAIL async_reset: res_valid %b d_ready %b cnt %0d", bus.res_valid, bus.d_ready, dut.cnt_q);
    end
    reset_n = 1'b1;
    send_word({3'd0, 3'd0, 3'd0, 3'd2}, 1'b0);
    check_res("word_after_reset", 9'h002);
    consume(9'h002);
  endtask

`ifdef RR_OTF_DIGIT_CHECK_EN
  task automatic test_digit_check;
    send_word({3'b100, 3'd0, 3'd0, 3'd0}, 1'b0);
    check_res("word_illegal", 9'h100);
    checks++;
    if (bus.err !== 1'b1) begin
      fails++;
      $display("FAIL err_set: got %b want 1", bus.err);
    end
    consume(9'h100);
    send_word({3'd1, 3'd0, 3'd0, 3'd0}, 1'b0);
    check_res("word_legal", 9'h040);
    checks++;
    if (bus.err !== 1'b0) begin
      fails++;
      $display("FAIL err_clear: got %b want 0", bus.err);
    end
    consume(9'h040);
  endtask
`endif

  initial begin
    bus.d_in      = '0;
    bus.d_valid   = 1'b0;
    bus.res_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    test_reset();
    test_basic_words();
    test_back_to_back_stall();
    test_reset_mid_word();
`ifdef RR_OTF_DIGIT_CHECK_EN
    test_digit_check();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/rr_otf_convert.md
# rR_otf_convert

Serial on-the-fly converter from radix-RADIX signed-digit (MSDF) form to conventional two's complement. It accepts one redundant digit per handshake, most significant digit first, and maintains the Q/QM register pair so no carry-propagate addition is needed. After WIDTH digits it presents a registered binary word. It sits at the output of the online multiplier/adder datapath and turns digit streams back into plain binary for the host side.

## Interface
- RADIX, 4: digit radix; power of two, ≥4; K = log2(RADIX).
- WIDTH, 4: digits per word, ≥2.
- Derived D = K+1: digit bit width. B = WIDTH*K+1: result width.
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- d_in  in  D  signed two's-complement digit, legal range -(RADIX-1)..(RADIX-1).
- d_valid  in  1  d_in valid.
- d_ready  out  1  converter accepts a digit this cycle.
- res  out  B  signed integer result, sum of d_i*RADIX^(WIDTH-1-i), where i=0 is the first digit.
- res_valid  out  1  res holds a completed word.
- res_ready  in  1  consumer takes res.
- err  out  1  only with RR_OTF_DIGIT_CHECK_EN; see Configuration.

## Operation
- States: ACCUM and DONE. Reset enters ACCUM with Q=0, QM=-1 (all ones), cnt=0, res=0, res_valid=0, d_ready=1, err=0.
- ACCUM: d_ready=1. A digit is accepted on a cycle where d_valid && d_ready.
- Update for an accepted digit d, with all values B bits wide and wraparound forbidden by range:
  - d≥0: Q ← Q*RADIX + d.
  - d<0: Q ← QM*RADIX + (RADIX+d).
  - d>0: QM ← Q*RADIX + (d-1).
  - d≤0: QM ← QM*RADIX + (RADIX-1+d).
  - Implement both as a shift of the selected register left by K bits plus a K-bit append. No adder wider than K bits.
- cnt increments on each accept. When the WIDTH-th digit is accepted (cnt==WIDTH-1):
  - res ← the updated Q value, res_valid←1 on the same edge.
  - Move to DONE, cnt←0, Q←0, QM←-1.
- DONE: d_ready=0 regardless of res_ready; d_valid is ignored. res and res_valid are held stable while res_ready=0.
- res_valid && res_ready: res_valid←0, return to ACCUM. d_ready rises the following cycle; there is no same-cycle overlap.
- res retains the last value after consumption.
- Invariant, checkable by assertion in ACCUM: QM == Q-1 modulo 2^B.
- Reset mid-word discards the partial word; there is no partial output.

## Timing
- Result latency: res_valid is registered high one edge after the last digit's accept edge, i.e. it is visible in the cycle after the last accept.
- Minimum period is WIDTH+1 cycles per word: WIDTH accept cycles plus one DONE cycle.
- d_ready is a pure function of state, with no combinational path from res_ready.
- All outputs are registered except d_ready, which is decoded from the state flop.
- reset_n asserts asynchronously; deassertion is synchronised externally.

## Configuration
- RR_OTF_DIGIT_CHECK_EN defined:
  - err port exists.
  - An accepted d_in equal to the unused code -RADIX (MSB set, rest zero) sets err.
  - err is sticky for the word, is reported alongside res_valid, and clears when the word is consumed.
  - The illegal digit is still processed as -RADIX, so res is arithmetically defined.
- RR_OTF_DIGIT_CHECK_EN undefined: no err port and no check logic; illegal codes are undefined behaviour.

## Structure
- Shared package rR_pkg:
  - digit-width function clog2(RADIX)+1;
  - result-width function WIDTH*K+1;
  - signed-digit typedef helpers;
  - state enum {ACCUM, DONE}.
- One sub-module, rR_sd_digit_append. It is combinational: it maps d to the K-bit append values for Q and QM and the select bits (use-QM-for-Q, use-Q-for-QM).
- Counter, state machine and Q/QM registers stay in the top module.

## Test plan
(RADIX=4, WIDTH=4, D=3, B=9.)
- Digits 3,0,0,0, no stalls → res=9'h0C0 (192), res_valid exactly one cycle after the 4th accept.
- Digits 1,-3,2,-1 → res=9'h017 (23). QM==Q-1 after every accept.
- Digits -3,-3,-3,-3 → res=9'h101 (-255). Digits 0,0,0,0 → res=9'h000.
- res_ready held low 3 cycles after res_valid, with d_valid=1 throughout → res stable, d_ready=0, no digit consumed. The next word starts the cycle after the handshake.
- reset_n pulsed low after 2 digits of word 1,1,1,1, then digits 0,0,0,2 → res=9'h002, and res_valid was never raised for the aborted word.
- With RR_OTF_DIGIT_CHECK_EN: digits 3'b100,0,0,0 → err=1 with res_valid, res=9'h100 (-256). err=0 for the following legal word.
